// File: rtl/wb_retire_buf.sv
// Write-back stage with a DEPTH-entry in-order retire buffer draining into a stallable RF port.
// Optional same-cycle bypass of an entry pushed into an empty buffer: define WB_BYPASS_EN.
module wb_retire_buf #(
   parameter int unsigned  DATA_W = 32,
   parameter int unsigned  ADDR_W = 5,
   parameter int unsigned  DEPTH  = 2,
   localparam int unsigned BUS_W  = 1 + 3 * DATA_W + ADDR_W
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     mem_wb_valid,
   output logic                     wb_allowin,
   input  logic [BUS_W-1:0]         mem_wb_bus,
   input  logic                     rf_wr_ready,
   output logic [ADDR_W+DATA_W:0]   wb_id_bus,
   output logic [2**ADDR_W-1:0]     pending_mask,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata,
   output logic [DATA_W-1:0]        debug_wb_pc,
   output logic [3:0]               debug_wb_rf_we,
   output logic [ADDR_W-1:0]        debug_wb_rf_wnum,
   output logic [DATA_W-1:0]        debug_wb_rf_wdata
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // Payload storage is deliberately unreset; every consumer is gated by validity.
   logic              ent_gr_we  [DEPTH];
   logic [DATA_W-1:0] ent_pc     [DEPTH];
   logic [DATA_W-1:0] ent_result [DEPTH];
   logic [ADDR_W-1:0] ent_dest   [DEPTH];

   logic              in_gr_we;
   logic [DATA_W-1:0] in_pc, in_inst, in_result;
   logic [ADDR_W-1:0] in_dest;
   logic              unused_inst;

   logic              push, pop, pop_stored, store, stored_valid, bypass;
   logic              head_valid, head_gr_we;
   logic [DATA_W-1:0] head_pc, head_result;
   logic [ADDR_W-1:0] head_dest;

   assign in_gr_we    = mem_wb_bus[BUS_W-1];
   assign in_pc       = mem_wb_bus[ADDR_W+2*DATA_W +: DATA_W];
   assign in_inst     = mem_wb_bus[ADDR_W+DATA_W +: DATA_W];
   assign in_result   = mem_wb_bus[ADDR_W +: DATA_W];
   assign in_dest     = mem_wb_bus[ADDR_W-1:0];
   assign unused_inst = ^in_inst;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign wb_allowin   = (count_q != CNT_W'(DEPTH));
   assign push         = mem_wb_valid & wb_allowin;
   assign stored_valid = (count_q != '0);

   always_comb begin
      head_valid  = stored_valid;
      head_gr_we  = ent_gr_we[rd_ptr_q];
      head_pc     = ent_pc[rd_ptr_q];
      head_result = ent_result[rd_ptr_q];
      head_dest   = ent_dest[rd_ptr_q];
      bypass      = 1'b0;
`ifdef WB_BYPASS_EN
      // resetn gate keeps a held mem_wb_valid from producing a write during reset.
      if (push && !stored_valid && resetn) begin
         bypass      = 1'b1;
         head_valid  = 1'b1;
         head_gr_we  = in_gr_we;
         head_pc     = in_pc;
         head_result = in_result;
         head_dest   = in_dest;
      end
`endif
   end

   assign pop        = head_valid & (~head_gr_we | rf_wr_ready);
   assign pop_stored = pop & ~bypass;
   // A bypassed entry that retires immediately never occupies a slot.
   assign store      = push & ~(bypass & pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (store)      wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_stored) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (store && !pop_stored)      count_d = count_q + CNT_W'(1);
      else if (!store && pop_stored) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         ent_gr_we[wr_ptr_q]  <= in_gr_we;
         ent_pc[wr_ptr_q]     <= in_pc;
         ent_result[wr_ptr_q] <= in_result;
         ent_dest[wr_ptr_q]   <= in_dest;
      end
   end

   always_comb begin
      logic [PTR_W-1:0] idx;
      idx          = rd_ptr_q;
      pending_mask = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         if (k < int'(count_q) && ent_gr_we[idx] && ent_dest[idx] != '0) begin
            pending_mask[ent_dest[idx]] = 1'b1;
         end
         idx = ptr_inc(idx);
      end
`ifdef WB_BYPASS_EN
      if (bypass && in_gr_we && in_dest != '0) pending_mask[in_dest] = 1'b1;
`endif
   end

   assign rf_we             = head_valid & head_gr_we;
   assign rf_waddr          = head_valid ? head_dest : '0;
   assign rf_wdata          = head_valid ? head_result : '0;
   assign wb_id_bus         = {rf_we, rf_waddr, rf_wdata};
   assign debug_wb_pc       = pop ? head_pc : '0;
   assign debug_wb_rf_we    = {4{pop & head_gr_we}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_retire_buf.sv
// Directed bench for wb_retire_buf: a queue scoreboard of buffered entries predicts every output
// each cycle; directed checks cover latency, stall hold, drain rate and mid-stall reset.
module tb_wb_retire_buf;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 2;
   localparam int BUS_W  = 1 + 3 * DATA_W + ADDR_W;

   logic                   clk, resetn, mem_wb_valid, wb_allowin, rf_wr_ready;
   logic [BUS_W-1:0]       mem_wb_bus;
   logic [ADDR_W+DATA_W:0] wb_id_bus;
   logic [31:0]            pending_mask;
   logic                   rf_we;
   logic [ADDR_W-1:0]      rf_waddr, debug_wb_rf_wnum;
   logic [DATA_W-1:0]      rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
   logic [3:0]             debug_wb_rf_we;

   logic        in_gr_we;
   logic [31:0] in_pc, in_inst, in_result;
   logic [4:0]  in_dest;
   assign mem_wb_bus = {in_gr_we, in_pc, in_inst, in_result, in_dest};

   typedef struct {
      logic        gr_we;
      logic [31:0] pc;
      logic [31:0] result;
      logic [4:0]  dest;
   } ent_t;

   ent_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   dut_retired = 0;
   int   r0;
   logic m_push, m_pop, m_bypass;
   logic [31:0] next_pc;

   wb_retire_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .mem_wb_valid      (mem_wb_valid),
      .wb_allowin        (wb_allowin),
      .mem_wb_bus        (mem_wb_bus),
      .rf_wr_ready       (rf_wr_ready),
      .wb_id_bus         (wb_id_bus),
      .pending_mask      (pending_mask),
      .rf_we             (rf_we),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_we    (debug_wb_rf_we),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected [TB] summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [31:0] pc,
                        input logic [31:0] res, input logic [4:0] dest, input logic rdy);
      mem_wb_valid = v;
      in_gr_we     = we;
      in_pc        = pc;
      in_inst      = ~pc;
      in_result    = res;
      in_dest      = dest;
      rf_wr_ready  = rdy;
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, rdy);
   endtask

   // Predict all outputs from the scoreboard and the current inputs.
   task automatic compare_all();
      ent_t        h;
      logic        hv, we_e;
      logic [31:0] mask;
      logic [4:0]  addr_e;
      logic [31:0] data_e;
      h.gr_we = 1'b0; h.pc = '0; h.result = '0; h.dest = '0;
      hv       = 1'b0;
      m_bypass = 1'b0;
      m_push   = resetn && mem_wb_valid && (q.size() != DEPTH);
      if (q.size() > 0) begin
         h  = q[0];
         hv = 1'b1;
      end
`ifdef WB_BYPASS_EN
      else if (m_push) begin
         h.gr_we = in_gr_we; h.pc = in_pc; h.result = in_result; h.dest = in_dest;
         hv = 1'b1;
         m_bypass = 1'b1;
      end
`endif
      m_pop = hv && (!h.gr_we || rf_wr_ready);
      mask  = '0;
      foreach (q[i]) if (q[i].gr_we && q[i].dest != 0) mask[q[i].dest] = 1'b1;
      if (m_bypass && h.gr_we && h.dest != 0) mask[h.dest] = 1'b1;
      we_e   = hv & h.gr_we;
      addr_e = hv ? h.dest : 5'd0;
      data_e = hv ? h.result : 32'd0;
      check("allowin", 128'(wb_allowin), 128'(q.size() != DEPTH));
      check("rf_we", 128'(rf_we), 128'(we_e));
      check("rf_waddr", 128'(rf_waddr), 128'(addr_e));
      check("rf_wdata", 128'(rf_wdata), 128'(data_e));
      check("wb_id_bus", 128'(wb_id_bus), 128'({we_e, addr_e, data_e}));
      check("pending_mask", 128'(pending_mask), 128'(mask));
      check("dbg_pc", 128'(debug_wb_pc), 128'(m_pop ? h.pc : 32'd0));
      check("dbg_we", 128'(debug_wb_rf_we), 128'({4{m_pop & h.gr_we}}));
      check("dbg_wnum", 128'(debug_wb_rf_wnum), 128'(addr_e));
      check("dbg_wdata", 128'(debug_wb_rf_wdata), 128'(data_e));
   endtask

   // Called at posedge+1 after inputs are driven; returns at the next posedge+1.
   task automatic tick();
      ent_t e;
      #1;
      compare_all();
      if (debug_wb_rf_we != 4'h0 || debug_wb_pc != 32'h0) dut_retired++;
      e.gr_we = in_gr_we; e.pc = in_pc; e.result = in_result; e.dest = in_dest;
      @(posedge clk);
      if (m_pop && !m_bypass) q.delete(0);
      if (m_push && !(m_bypass && m_pop)) q.push_back(e);
      #1;
   endtask

   initial begin
      resetn = 1'b0;
      idle(1'b0);
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      check("rst_allowin", 128'(wb_allowin), 128'(1'b1));
      check("rst_rf_we", 128'(rf_we), 128'(1'b0));
      check("rst_mask", 128'(pending_mask), 128'(32'h0));
      resetn = 1'b1;

      // Single write-back with ready high.
      drive(1'b1, 1'b1, 32'h1c000000, 32'h12345678, 5'd5, 1'b1);
      tick();
      idle(1'b1);
`ifndef WB_BYPASS_EN
      #1;
      check("t1_rf_we", 128'(rf_we), 128'(1'b1));
      check("t1_waddr", 128'(rf_waddr), 128'(5'd5));
      check("t1_wdata", 128'(rf_wdata), 128'(32'h12345678));
      check("t1_dbg_we", 128'(debug_wb_rf_we), 128'(4'hf));
      check("t1_dbg_pc", 128'(debug_wb_pc), 128'(32'h1c000000));
`endif
      tick();
      #1;
      check("t1_empty_allowin", 128'(wb_allowin), 128'(1'b1));
      check("t1_empty_rf_we", 128'(rf_we), 128'(1'b0));

      // Fill under stall, hold, then drain.
      drive(1'b1, 1'b1, 32'h1c000100, 32'h33, 5'd3, 1'b0);
      tick();
      drive(1'b1, 1'b1, 32'h1c000104, 32'h77, 5'd7, 1'b0);
      tick();
      idle(1'b0);
      #1;
      check("t2_full_allowin", 128'(wb_allowin), 128'(1'b0));
      check("t2_mask", 128'(pending_mask), 128'(32'h88));
      check("t2_hold_addr", 128'(rf_waddr), 128'(5'd3));
      repeat (5) tick();
      check("t2_still_held", 128'(rf_waddr), 128'(5'd3));
      idle(1'b1);
      repeat (3) tick();
      #1;
      check("t2_allowin_back", 128'(wb_allowin), 128'(1'b1));

      // No-write entry retires despite ready low.
      drive(1'b1, 1'b0, 32'h1c000004, 32'hdead, 5'd9, 1'b0);
      tick();
      idle(1'b0);
`ifndef WB_BYPASS_EN
      #1;
      check("t3_dbg_pc", 128'(debug_wb_pc), 128'(32'h1c000004));
      check("t3_rf_we", 128'(rf_we), 128'(1'b0));
`endif
      tick();

      // Streaming from a full buffer: one retire per cycle.
      drive(1'b1, 1'b1, 32'h1c000200, 32'h200, 5'd1, 1'b0);
      tick();
      drive(1'b1, 1'b1, 32'h1c000204, 32'h204, 5'd2, 1'b0);
      tick();
      next_pc = 32'h1c000208;
      r0 = dut_retired;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, next_pc, next_pc ^ 32'h5a5a, 5'((i % 31) + 1), 1'b1);
         tick();
         if (m_push) next_pc = next_pc + 32'd4;
      end
      check("t4_rate", 128'(dut_retired - r0), 128'(20));
      idle(1'b1);
      repeat (3) tick();

      // Write to r0: issued but never pending.
      drive(1'b1, 1'b1, 32'h1c000300, 32'habc, 5'd0, 1'b0);
      tick();
      idle(1'b0);
      #1;
      check("t5_mask", 128'(pending_mask), 128'(32'h0));
      check("t5_rf_we", 128'(rf_we), 128'(1'b1));
      check("t5_waddr", 128'(rf_waddr), 128'(5'd0));
      tick();
      idle(1'b1);
      repeat (2) tick();

      // Reset in the middle of a stall with two entries buffered.
      drive(1'b1, 1'b1, 32'h1c000400, 32'h11, 5'd4, 1'b0);
      tick();
      drive(1'b1, 1'b1, 32'h1c000404, 32'h22, 5'd6, 1'b0);
      tick();
      idle(1'b0);
      repeat (2) tick();
      #1;
      resetn = 1'b0;
      #1;
      q.delete();
      check("t6_rst_rf_we", 128'(rf_we), 128'(1'b0));
      check("t6_rst_mask", 128'(pending_mask), 128'(32'h0));
      check("t6_rst_allowin", 128'(wb_allowin), 128'(1'b1));
      check("t6_rst_idbus", 128'(wb_id_bus), 128'(38'h0));
      compare_all();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      idle(1'b1);
      r0 = dut_retired;
      repeat (4) tick();
      check("t6_no_stale", 128'(dut_retired - r0), 128'(0));

`ifdef WB_BYPASS_EN
      drive(1'b1, 1'b1, 32'h1c000500, 32'h55, 5'd8, 1'b1);
      #1;
      check("t7_bypass_we", 128'(rf_we), 128'(1'b1));
      check("t7_bypass_addr", 128'(rf_waddr), 128'(5'd8));
      check("t7_bypass_dbg", 128'(debug_wb_rf_we), 128'(4'hf));
      tick();
      idle(1'b1);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wb_retire_buf.md
Name: wb_retire_buf

Overview:
- Parametrised write-back stage: successor to the single-entry WB stage.
- Accepts retiring instructions from MEM over the valid/allowin handshake into a DEPTH-entry in-order retire buffer.
- Drains the buffer head into a register-file write port that may stall via rf_wr_ready.
- Exports a head-entry forwarding bus and a pending-destination scoreboard mask to ID, plus the difftest debug trace.

Parameters:
- DATA_W, 32, width of pc, inst and result fields and of RF write data.
- ADDR_W, 5, RF address width; scoreboard mask width is 2**ADDR_W.
- DEPTH, 2, retire buffer entries; legal for any value >= 1.
- BUS_W, 1+3*DATA_W+ADDR_W, mem_wb_bus width; derived, not overridden.

Ports:
- clk  in  1  stage clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- mem_wb_valid  in  1  MEM presents a valid entry.
- wb_allowin  out  1  buffer can accept this cycle.
- mem_wb_bus  in  BUS_W  {gr_we, pc, inst, result, dest}, gr_we at MSB.
- rf_wr_ready  in  1  RF port accepts a write this cycle.
- wb_id_bus  out  1+ADDR_W+DATA_W  {rf_we, rf_waddr, rf_wdata} of the head entry, for forwarding.
- pending_mask  out  2**ADDR_W  bit r set when any buffered entry has gr_we=1 and dest=r, r!=0.
- rf_we  out  1  RF write strobe.
- rf_waddr  out  ADDR_W  RF write address.
- rf_wdata  out  DATA_W  RF write data.
- debug_wb_pc  out  DATA_W  pc of the entry retiring this cycle.
- debug_wb_rf_we  out  4  {4{actual RF write this cycle}}.
- debug_wb_rf_wnum  out  ADDR_W  debug write number.
- debug_wb_rf_wdata  out  DATA_W  debug write data.

Behaviour:
- Storage: circular buffer with wr_ptr, rd_ptr in 0..DEPTH-1 and count in 0..DEPTH. Pointers wrap from DEPTH-1 to 0; no power-of-two requirement.
- Async reset (resetn low): count=0, wr_ptr=rd_ptr=0. All outputs then read 0 except wb_allowin=1. Entry payload registers are not reset; every output is gated by entry validity.
- wb_allowin = (count != DEPTH). It is registered-state only, with no combinational path from rf_wr_ready.
- push = mem_wb_valid & wb_allowin: write bus into entry wr_ptr, then increment wr_ptr.
- head_valid = (count != 0).
- pop = head_valid & (~head.gr_we | rf_wr_ready): increment rd_ptr.
- count update: push only +1, pop only -1, both or neither unchanged. Full with a simultaneous pop does not accept, because allowin is already 0 that cycle.
- Latency: an entry pushed in cycle N is the head no earlier than N+1. Write is earliest at N+1 when the buffer was empty.
- rf_we = head_valid & head.gr_we; rf_waddr = head.dest; rf_wdata = head.result.
- rf_we stays asserted across rf_wr_ready=0 cycles with stable address and data until accepted.
- Entries with gr_we=0 retire in one cycle with no RF write. dest=0 writes are still issued; the RF ignores them.
- wb_id_bus reflects the head entry every cycle, independent of rf_wr_ready.
- pending_mask is combinational over all valid entries and excludes dest=0. It includes the head until it pops.
- Debug trace:
  - debug_wb_pc = head.pc when pop, else 0.
  - debug_wb_rf_we = {4{pop & head.gr_we}}.
  - debug_wb_rf_wnum = head.dest; debug_wb_rf_wdata = head.result.
- Ordering: retirement is strictly in push order; no entry is dropped or duplicated.
- Reset asserted mid-operation discards all buffered entries immediately. No write occurs after resetn falls.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when count=0 and push, the incoming entry is also presented as the head in the same cycle.
  - rf_we, wb_id_bus, pending_mask and the debug trace take the incoming fields.
  - If it pops that cycle, it is not stored and count stays 0; otherwise it is stored normally.
  - Zero-latency retire.
- Undefined: there is no combinational path from mem_wb_bus or mem_wb_valid to any output, and the minimum latency is 1 cycle.

Test Plan:
- Reset, then one push {gr_we=1, pc=0x1c000000, result=0x12345678, dest=5}, rf_wr_ready=1 -> next cycle rf_we=1, waddr=5, wdata=0x12345678, debug_wb_rf_we=4'hf, debug_wb_pc=0x1c000000; count returns to 0.
- DEPTH=2, rf_wr_ready=0, push dest=3 then dest=7 -> wb_allowin=0 after the second push; pending_mask has bits 3 and 7; rf_we held at waddr=3 for 5 cycles. Then ready=1 -> writes 3 then 7 on consecutive cycles, and allowin returns to 1.
- Push gr_we=0 entry pc=0x1c000004 with rf_wr_ready=0 -> retires next cycle, rf_we=0, debug_wb_rf_we=0, debug_wb_pc=0x1c000004.
- Full buffer, rf_wr_ready=1, mem_wb_valid held high for 20 cycles with incrementing pc -> one retire per cycle, in order, no gaps beyond the allowin bubble, no lost pc.
- Push dest=0 gr_we=1 -> pending_mask stays 0; rf_we=1 with waddr=0.
- Assert resetn low while 2 entries are pending, mid-stall -> outputs zero asynchronously; after release no stale write appears. With WB_BYPASS_EN, a push into empty with ready=1 -> write in the same cycle.
